// File: rtl/alu_pkg.sv
// Shared ALU command types: opcode enum and the packed {op, a, b} command word.
// Used by the issue queue and by the combinational ALU stage.
package alu_pkg;

  localparam int ALU_WIDTH = 8;

  typedef enum logic [1:0] {
    ALU_ADD = 2'd0,
    ALU_SUB = 2'd1,
    ALU_AND = 2'd2,
    ALU_OR  = 2'd3
  } alu_op_e;

  typedef struct packed {
    alu_op_e                op;
    logic [ALU_WIDTH-1:0]   a;
    logic [ALU_WIDTH-1:0]   b;
  } alu_cmd_t;

endpackage

// File: rtl/alu_cmd_fifo.sv
// DEPTH-entry FIFO of ALU commands with occupancy count and a combinational
// head output that reads as all zeros while empty.
module alu_cmd_fifo
  import alu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       nreset,
  input  logic                       push,
  input  logic                       pop,
  input  alu_cmd_t                   wr_cmd,
  output alu_cmd_t                   head,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  alu_cmd_t        mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!nreset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: the storage array is deliberately not reset; count alone says which
  // entries are live, so the array needs no reset muxes.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_cmd;
  end

  // NOTE: default assignment first, so no path leaves head unassigned (no latch).
  always_comb begin
    head = '0;
    if (!empty) head = mem[rd_ptr];
  end

endmodule

// File: rtl/alu_issue_queue.sv
// Command FIFO in front of an external combinational ALU stage, plus a result
// register with valid/ready handshake so the ALU path can be back-pressured.
module alu_issue_queue
  import alu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       nreset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [1:0]                 in_op,
  input  logic [WIDTH-1:0]           in_a,
  input  logic [WIDTH-1:0]           in_b,
  output logic [1:0]                 alu_op,
  output logic [WIDTH-1:0]           alu_a,
  output logic [WIDTH-1:0]           alu_b,
  input  logic [WIDTH-1:0]           alu_out,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [WIDTH-1:0]           res_data,
  output logic [1:0]                 res_op,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  alu_cmd_t in_cmd;
  alu_cmd_t head;
  logic     full;
  logic     empty;
  logic     push;
  logic     pop;
  logic     slot_free;

  assign in_cmd = '{op: alu_op_e'(in_op), a: in_a, b: in_b};

  // Full blocks input even when a pop happens this cycle: no bypass path.
  assign in_ready  = !full;
  assign push      = in_valid && in_ready;
  assign slot_free = !res_valid || res_ready;
  assign pop       = !empty && slot_free;

  alu_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk    (clk),
    .nreset (nreset),
    .push   (push),
    .pop    (pop),
    .wr_cmd (in_cmd),
    .head   (head),
    .count  (count),
    .full   (full),
    .empty  (empty)
  );

  assign alu_op = head.op;
  assign alu_a  = head.a;
  assign alu_b  = head.b;

  always_ff @(posedge clk) begin
    if (!nreset) begin
      res_valid <= 1'b0;
      res_data  <= '0;
      res_op    <= '0;
    end else if (pop) begin
      res_valid <= 1'b1;
      res_data  <= alu_out;
      res_op    <= alu_op;
    end else if (res_ready) begin
      // Consumed with nothing to refill the slot.
      res_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_issue_queue.sv
// Directed bench for alu_issue_queue (DEPTH=4) driving a behavioural ALU stage
// from alu_*; expected results are hand-computed constants.
module tb_alu_issue_queue;
  import alu_pkg::*;

  localparam int DEPTH = 4;
  localparam int WIDTH = 8;

  logic                       clk = 1'b0;
  logic                       nreset;
  logic                       in_valid;
  logic                       in_ready;
  logic [1:0]                 in_op;
  logic [WIDTH-1:0]           in_a;
  logic [WIDTH-1:0]           in_b;
  logic [1:0]                 alu_op;
  logic [WIDTH-1:0]           alu_a;
  logic [WIDTH-1:0]           alu_b;
  logic [WIDTH-1:0]           alu_out;
  logic                       res_valid;
  logic                       res_ready;
  logic [WIDTH-1:0]           res_data;
  logic [1:0]                 res_op;
  logic [$clog2(DEPTH+1)-1:0] count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  alu_issue_queue #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk       (clk),
    .nreset    (nreset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_a      (in_a),
    .in_b      (in_b),
    .alu_op    (alu_op),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_out   (alu_out),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_op    (res_op),
    .count     (count)
  );

  // Combinational ALU stage owned by the parent.
  always_comb begin
    alu_out = '0;
    case (alu_op_e'(alu_op))
      ALU_ADD: alu_out = alu_a + alu_b;
      ALU_SUB: alu_out = alu_a - alu_b;
      ALU_AND: alu_out = alu_a & alu_b;
      ALU_OR:  alu_out = alu_a | alu_b;
      default: alu_out = '0;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Advance one edge; outputs are then sampled 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    in_valid = 1'b1;
    in_op    = op;
    in_a     = a;
    in_b     = b;
  endtask

  // Stream vectors: op, a, b, expected result.
  logic [1:0] s_op  [10] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd0};
  logic [7:0] s_a   [10] = '{8'h02, 8'hF0, 8'hF0, 8'hFF, 8'h10, 8'hAA, 8'hA0, 8'h7F, 8'h00, 8'h12};
  logic [7:0] s_b   [10] = '{8'h03, 8'h3C, 8'h0F, 8'h02, 8'h01, 8'h55, 8'h05, 8'h01, 8'h00, 8'h34};
  logic [7:0] s_exp [10] = '{8'hFF, 8'h30, 8'hFF, 8'h01, 8'h0F, 8'h00, 8'hA5, 8'h80, 8'h00, 8'h46};

  // Backpressure vectors; the sixth is refused while the queue is full.
  logic [1:0] b_op  [6] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd3};
  logic [7:0] b_a   [6] = '{8'h01, 8'h05, 8'h0F, 8'h11, 8'h80, 8'hFF};
  logic [7:0] b_b   [6] = '{8'h02, 8'h07, 8'h3C, 8'h22, 8'h80, 8'h00};
  logic [7:0] b_exp [5] = '{8'h03, 8'hFE, 8'h0C, 8'h33, 8'h00};

  initial begin
    // 1: reset held two edges with in_valid asserted
    nreset    = 1'b0;
    res_ready = 1'b1;
    drive(2'd0, 8'h01, 8'h01);
    step();
    step();
    nreset   = 1'b1;
    in_valid = 1'b0;
    check("rst_count", 32'(count), 32'd0);
    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_res_data", 32'(res_data), 32'h00);
    check("rst_res_op", 32'(res_op), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_alu_a_empty", 32'(alu_a), 32'h00);

    // 2: single ADD 05+03
    drive(2'd0, 8'h05, 8'h03);
    step();
    in_valid = 1'b0;
    check("single_count1", 32'(count), 32'd1);
    check("single_not_yet", 32'(res_valid), 32'd0);
    check("single_alu_a", 32'(alu_a), 32'h05);
    check("single_alu_b", 32'(alu_b), 32'h03);
    step();
    check("single_valid", 32'(res_valid), 32'd1);
    check("single_data", 32'(res_data), 32'h08);
    check("single_op", 32'(res_op), 32'd0);
    check("single_count0", 32'(count), 32'd0);
    check("single_alu_empty", 32'(alu_op), 32'd0);
    step();
    check("single_drained", 32'(res_valid), 32'd0);

    // 3: ten back-to-back commands, one result per cycle, pointers wrap
    for (int k = 0; k <= 10; k++) begin
      if (k < 10) drive(s_op[k], s_a[k], s_b[k]);
      else        in_valid = 1'b0;
      step();
      if (k >= 1) begin
        check($sformatf("stream_valid_%0d", k - 1), 32'(res_valid), 32'd1);
        check($sformatf("stream_data_%0d", k - 1), 32'(res_data), 32'(s_exp[k-1]));
        check($sformatf("stream_op_%0d", k - 1), 32'(res_op), 32'(s_op[k-1]));
      end
      if (k < 10) check($sformatf("stream_count_%0d", k), 32'(count), 32'd1);
    end
    check("stream_count_end", 32'(count), 32'd0);
    step();
    check("stream_drained", 32'(res_valid), 32'd0);

    // 4: backpressure
    res_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      drive(b_op[i], b_a[i], b_b[i]);
      step();
    end
    in_valid = 1'b0;
    check("bp_count_full", 32'(count), 32'd4);
    check("bp_in_ready", 32'(in_ready), 32'd0);
    check("bp_res_valid", 32'(res_valid), 32'd1);
    check("bp_res_data0", 32'(res_data), 32'(b_exp[0]));
    step();
    step();
    check("bp_data_stable", 32'(res_data), 32'(b_exp[0]));
    check("bp_op_stable", 32'(res_op), 32'd0);
    check("bp_count_stable", 32'(count), 32'd4);
    res_ready = 1'b1;
    for (int i = 1; i < 5; i++) begin
      step();
      check($sformatf("bp_data_%0d", i), 32'(res_data), 32'(b_exp[i]));
      check($sformatf("bp_op_%0d", i), 32'(res_op), 32'(b_op[i]));
      check($sformatf("bp_count_%0d", i), 32'(count), 32'(4 - i));
    end
    step();
    check("bp_drained", 32'(res_valid), 32'd0);

    // 5: push and pop on the same edge keep count at 2
    res_ready = 1'b0;
    drive(2'd0, 8'h03, 8'h04);
    step();
    drive(2'd1, 8'h09, 8'h04);
    step();
    drive(2'd2, 8'hFF, 8'h81);
    step();
    check("sim_count_before", 32'(count), 32'd2);
    check("sim_held", 32'(res_data), 32'h07);
    res_ready = 1'b1;
    drive(2'd3, 8'h40, 8'h02);
    step();
    in_valid = 1'b0;
    check("sim_count_same", 32'(count), 32'd2);
    check("sim_data1", 32'(res_data), 32'h05);
    step();
    check("sim_data2", 32'(res_data), 32'h81);
    step();
    check("sim_data3", 32'(res_data), 32'h42);
    check("sim_op3", 32'(res_op), 32'd3);
    step();
    check("sim_drained", 32'(res_valid), 32'd0);

    // 6: reset mid-stream with count=3 and a held result
    res_ready = 1'b0;
    drive(2'd3, 8'h0F, 8'hF0);
    step();
    drive(2'd1, 8'h20, 8'h01);
    step();
    drive(2'd2, 8'h33, 8'h0F);
    step();
    drive(2'd0, 8'h11, 8'h11);
    step();
    in_valid = 1'b0;
    check("mid_count3", 32'(count), 32'd3);
    check("mid_valid", 32'(res_valid), 32'd1);
    check("mid_data", 32'(res_data), 32'hFF);
    nreset = 1'b0;
    step();
    nreset = 1'b1;
    check("mid_rst_count", 32'(count), 32'd0);
    check("mid_rst_valid", 32'(res_valid), 32'd0);
    check("mid_rst_data", 32'(res_data), 32'h00);
    check("mid_rst_op", 32'(res_op), 32'd0);
    check("mid_rst_alu_a", 32'(alu_a), 32'h00);
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    res_ready = 1'b1;
    drive(2'd0, 8'h21, 8'h21);
    step();
    in_valid = 1'b0;
    check("post_count1", 32'(count), 32'd1);
    check("post_alu_a", 32'(alu_a), 32'h21);
    step();
    check("post_valid", 32'(res_valid), 32'd1);
    check("post_data", 32'(res_data), 32'h42);
    check("post_op", 32'(res_op), 32'd0);
    check("post_count0", 32'(count), 32'd0);
    step();
    check("post_drained", 32'(res_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
